// File: rtl/execute_muldiv_if.sv
// Execute-stage M-extension bus: instruction in, result out.
// Master drives operands/controls, slave is the muldiv unit.
interface execute_muldiv_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] rs1_in;
  logic [XLEN-1:0] rs2_in;
  logic            md_in;
  logic [2:0]      md_op_in;
  logic [4:0]      rd_address_in;
  logic            valid_in;
  logic            exception_in;
  logic            stall;
  logic            invalidate;
  logic            busy_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] md_result_out;
  logic [4:0]      rd_address_out;
  logic            valid_out;

  modport master (
    output pc_in, rs1_in, rs2_in, md_in, md_op_in,
    output rd_address_in, valid_in, exception_in,
    output stall, invalidate,
    input  busy_out, pc_out, md_result_out,
    input  rd_address_out, valid_out
  );

  modport slave (
    input  pc_in, rs1_in, rs2_in, md_in, md_op_in,
    input  rd_address_in, valid_in, exception_in,
    input  stall, invalidate,
    output busy_out, pc_out, md_result_out,
    output rd_address_out, valid_out
  );
endinterface

// File: rtl/execute_muldiv.sv
// Multi-cycle multiply/divide unit for the execute stage.
// Multiply has fixed latency; divide is restoring, 1 bit per edge.
module execute_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  execute_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_pc;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_res;
  logic [XLEN-1:0] r_pco;
  logic [4:0]      r_rdo;
  logic            r_vld;

  logic            w_start;
  logic            w_in_sd;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_start = (r_state == S_IDLE) && bus.valid_in
                && bus.md_in && !bus.exception_in
                && !bus.invalidate && !bus.stall;

  // Signed divide ops are DIV/REM (funct3 bit 0 clear)
  assign w_in_sd = !bus.md_op_in[0];
  assign w_abs_a = (w_in_sd && bus.rs1_in[XLEN-1])
                 ? -bus.rs1_in : bus.rs1_in;
  assign w_abs_b = (w_in_sd && bus.rs2_in[XLEN-1])
                 ? -bus.rs2_in : bus.rs2_in;

  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  // MULH: s*s, MULHSU: s*u, MULHU/MUL: u*u (low half is sign-agnostic)
  assign w_a_sgn = (r_op == 3'd1) || (r_op == 3'd2);
  assign w_b_sgn = (r_op == 3'd1);
  assign w_a_ext = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
  assign w_b_ext = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_mul_res = (r_op[1:0] == 2'd0)
                   ? w_prod[XLEN-1:0]
                   : w_prod[2*XLEN-1:XLEN];

  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic            w_sd;
  logic            w_neg_q;
  logic            w_neg_r;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;
  logic [XLEN-1:0] w_div_res;
  logic            w_dz;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_min;

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_sub    = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = !w_sub[XLEN];
  assign w_rem_nx = w_ge ? w_sub[XLEN-1:0]
                         : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

  assign w_sd    = !r_op[0];
  assign w_neg_q = w_sd && (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_neg_r = w_sd && r_a[XLEN-1];
  assign w_q_fin = w_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_r_fin = w_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_div_res = r_op[1] ? w_r_fin : w_q_fin;

  // Divide-by-zero and signed overflow resolve without iterating
  assign w_min = {1'b1, {(XLEN-1){1'b0}}};
  assign w_dz  = (r_b == '0);
  assign w_ovf = w_sd && (r_a == w_min) && (r_b == '1);

  always_comb begin
    w_spec_res = '0;
    unique case (1'b1)
      w_dz:    w_spec_res = r_op[1] ? r_a : '1;
      w_ovf:   w_spec_res = r_op[1] ? '0 : r_a;
      default: w_spec_res = '0;
    endcase
  end

  // Operation sequencer with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_pc    <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_res   <= '0;
      r_pco   <= '0;
      r_rdo   <= '0;
      r_vld   <= 1'b0;
    end else if (bus.invalidate) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a     <= bus.rs1_in;
            r_b     <= bus.rs2_in;
            r_op    <= bus.md_op_in;
            r_pc    <= bus.pc_in;
            r_rd    <= bus.rd_address_in;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= bus.md_op_in[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(MUL_CYCLES - 1)) begin
            r_res   <= w_mul_res;
            r_pco   <= r_pc;
            r_rdo   <= r_rd;
            r_vld   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (r_cnt == '0 && (w_dz || w_ovf)) begin
            r_res   <= w_spec_res;
            r_pco   <= r_pc;
            r_rdo   <= r_rd;
            r_vld   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            if (r_cnt == CW'(XLEN - 1)) begin
              r_res   <= w_div_res;
              r_pco   <= r_pc;
              r_rdo   <= r_rd;
              r_vld   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          if (!bus.stall) begin
            r_state <= S_IDLE;
            r_vld   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_out = w_start
                     || (r_state == S_MUL)
                     || (r_state == S_DIV);
  assign bus.md_result_out  = r_res;
  assign bus.pc_out         = r_pco;
  assign bus.rd_address_out = r_rdo;
  assign bus.valid_out      = r_vld;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: arithmetic reference model,
// per-cycle output compare and directed literal vectors.
module tb_execute_muldiv;

  localparam int MC = 2;

  logic clk = 1'b0;
  logic rst_n;

  execute_muldiv_if #(.XLEN(32)) bus ();

  execute_muldiv #(
    .XLEN(32),
    .MUL_CYCLES(MC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint p;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    if (op < 3'd4) return MC;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 32;
  endfunction

  int          m_ph;
  int          m_left;
  logic        m_vld;
  logic [31:0] m_res, m_pc, m_p_res, m_p_pc;
  logic [4:0]  m_rd, m_p_rd;
  logic        m_start;

  assign m_start = (m_ph == 0) && bus.valid_in && bus.md_in
                && !bus.exception_in && !bus.invalidate
                && !bus.stall;

  // Reference: phase 0 idle, 1 computing, 2 result held
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= 0;
      m_left <= 0;
      m_vld  <= 1'b0;
      m_res  <= '0;
      m_pc   <= '0;
      m_rd   <= '0;
    end else if (bus.invalidate) begin
      m_ph  <= 0;
      m_vld <= 1'b0;
    end else if (m_ph == 0) begin
      if (m_start) begin
        m_ph    <= 1;
        m_left  <= ref_lat(bus.md_op_in, bus.rs1_in, bus.rs2_in);
        m_p_res <= ref_res(bus.md_op_in, bus.rs1_in, bus.rs2_in);
        m_p_pc  <= bus.pc_in;
        m_p_rd  <= bus.rd_address_in;
      end
    end else if (m_ph == 1) begin
      if (m_left == 1) begin
        m_ph  <= 2;
        m_vld <= 1'b1;
        m_res <= m_p_res;
        m_pc  <= m_p_pc;
        m_rd  <= m_p_rd;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (!bus.stall) begin
      m_ph  <= 0;
      m_vld <= 1'b0;
    end
  end

  // Every-cycle compare against the reference
  always @(negedge clk) begin
    chk("cmp_busy", bus.busy_out, m_start || (m_ph == 1));
    chk("cmp_valid", bus.valid_out, m_vld);
    chk("cmp_result", bus.md_result_out, m_res);
    chk("cmp_pc", bus.pc_out, m_pc);
    chk("cmp_rd", bus.rd_address_out, m_rd);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
    int          ms;
    int          ds;
  } vec_t;

  vec_t vecs [17] = '{
    '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0, 0},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0, 0},
    '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2, 0, 0},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0},
    '{3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 2, 0, 0},
    '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0, 0},
    '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 0, 0},
    '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0},
    '{3'd7, 32'd5, 32'd0, 32'd5, 1, 0, 0},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 0},
    '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32, 0, 0},
    '{3'd4, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32, 5, 0},
    '{3'd6, 32'd20, 32'hFFFF_FFFA, 32'd2, 32, 0, 0},
    '{3'd7, 32'd100, 32'd7, 32'd2, 32, 0, 0},
    '{3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0, 0},
    '{3'd0, 32'd6, 32'd7, 32'd42, 2, 0, 3}
  };

  logic [31:0] pcv = 32'h0000_1000;
  logic [4:0]  rdv = 5'd1;

  task automatic run_op(input vec_t v);
    int n;
    logic [31:0] epc;
    logic [4:0]  erd;
    pcv = pcv + 32'd4;
    rdv = rdv + 5'd1;
    epc = pcv;
    erd = rdv;
    bus.md_op_in      = v.op;
    bus.rs1_in        = v.a;
    bus.rs2_in        = v.b;
    bus.pc_in         = epc;
    bus.rd_address_in = erd;
    bus.valid_in      = 1'b1;
    bus.md_in         = 1'b1;
    @(posedge clk); #1;
    bus.rs1_in        = ~v.a;
    bus.rs2_in        = v.b + 32'd3;
    bus.md_op_in      = v.op ^ 3'd1;
    bus.pc_in         = 32'hDEAD_0000;
    bus.rd_address_in = 5'd0;
    if (v.ms > 0) bus.stall = 1'b1;
    n = 0;
    while (bus.valid_out !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == v.ms) bus.stall = 1'b0;
    end
    bus.stall = 1'b0;
    chk("latency", 64'(n), 64'(v.lat));
    chk("result", bus.md_result_out, v.e);
    chk("pc_out", bus.pc_out, epc);
    chk("rd_out", bus.rd_address_out, erd);
    if (v.ds > 0) begin
      bus.stall = 1'b1;
      repeat (v.ds) begin
        @(posedge clk); #1;
        chk("hold_valid", bus.valid_out, 1'b1);
        chk("hold_result", bus.md_result_out, v.e);
      end
      bus.stall = 1'b0;
    end
    @(posedge clk); #1;
    chk("leave_valid", bus.valid_out, 1'b0);
    bus.valid_in = 1'b0;
    bus.md_in    = 1'b0;
  endtask

  int nv;

  initial begin
    rst_n             = 1'b0;
    bus.pc_in         = '0;
    bus.rs1_in        = '0;
    bus.rs2_in        = '0;
    bus.md_in         = 1'b0;
    bus.md_op_in      = '0;
    bus.rd_address_in = '0;
    bus.valid_in      = 1'b0;
    bus.exception_in  = 1'b0;
    bus.stall         = 1'b0;
    bus.invalidate    = 1'b0;

    chk("model_mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD),
        32'hFFFF_FFEB);
    chk("model_mulhu", ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
        32'hFFFF_FFFE);
    chk("model_div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2),
        32'hFFFF_FFFD);
    chk("model_rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2),
        32'hFFFF_FFFF);
    chk("model_lat", 64'(ref_lat(3'd5, 32'd5, 32'd0)), 64'd1);

    @(posedge clk); #1;
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_result", bus.md_result_out, 32'h0);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_rd", bus.rd_address_out, 5'h0);
    chk("rst_busy", bus.busy_out, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    bus.valid_in     = 1'b1;
    bus.md_in        = 1'b1;
    bus.exception_in = 1'b1;
    bus.md_op_in     = 3'd4;
    repeat (3) begin
      @(posedge clk); #1;
      chk("exc_busy", bus.busy_out, 1'b0);
      chk("exc_valid", bus.valid_out, 1'b0);
    end
    bus.exception_in = 1'b0;
    bus.md_in        = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("nonm_busy", bus.busy_out, 1'b0);
      chk("nonm_valid", bus.valid_out, 1'b0);
    end
    bus.valid_in = 1'b0;

    bus.md_op_in = 3'd5;
    bus.rs1_in   = 32'd100;
    bus.rs2_in   = 32'd7;
    bus.valid_in = 1'b1;
    bus.md_in    = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    bus.invalidate = 1'b1;
    @(posedge clk); #1;
    bus.invalidate = 1'b0;
    bus.valid_in   = 1'b0;
    bus.md_in      = 1'b0;
    chk("inv_valid", bus.valid_out, 1'b0);
    chk("inv_busy", bus.busy_out, 1'b0);
    run_op('{3'd0, 32'd3, 32'd4, 32'd12, 2, 0, 0});

    bus.md_op_in = 3'd4;
    bus.rs1_in   = 32'd1000;
    bus.rs2_in   = 32'd3;
    bus.valid_in = 1'b1;
    bus.md_in    = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.md_in    = 1'b0;
    #1;
    chk("arst_valid", bus.valid_out, 1'b0);
    chk("arst_result", bus.md_result_out, 32'h0);
    chk("arst_pc", bus.pc_out, 32'h0);
    chk("arst_busy", bus.busy_out, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid_out === 1'b1) nv++;
    end
    chk("arst_no_result", 64'(nv), 64'd0);

    run_op('{3'd3, 32'hFFFF_FFFF, 32'd2, 32'd1, 2, 0, 0});

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
